// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl: MEM-stage load/store sequencer for an Avalon-MM style data bus.
// Issues one word-aligned command per instruction. Load data is formatted
// combinationally in the response cycle. The stall request is driven from here.
// Optional macro LSU_TIMEOUT_EN adds a bus watchdog, sized by TIMEOUT_CYCLES.
module lsu_bus_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_req_read,
  input  logic        lsu_req_write,
  input  logic [2:0]  lsu_req_mem_op,
  input  logic [31:0] lsu_req_address,
  input  logic [31:0] lsu_req_writedata,
  input  logic        mem_stall_ext,
  output logic        lsu_stall_req,
  output logic        lsu_readdatavalid,
  output logic [31:0] lsu_readdata,
  output logic        lsu_bus_error,
  output logic        bus_read,
  output logic        bus_write,
  output logic [31:0] bus_address,
  output logic [3:0]  bus_byteenable,
  output logic [31:0] bus_writedata,
  input  logic        bus_waitrequest,
  input  logic        bus_readdatavalid,
  input  logic [31:0] bus_readdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_RD, S_DONE} state_t;

  state_t      r_state;
  logic        r_read;
  logic        r_write;
  logic [31:0] r_addr;
  logic [1:0]  r_lo;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [2:0]  r_op;
  logic        r_is_load;
  logic [31:0] r_held;

  logic        w_req;
  logic        w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_shift;
  logic [31:0] w_fmt;

  // A watchdog of fewer than two cycles cannot be represented.
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("lsu_bus_ctrl: TIMEOUT_CYCLES must be at least 2");
  end

  assign w_req          = lsu_req_read | lsu_req_write;
  assign bus_read       = r_read;
  assign bus_write      = r_write;
  assign bus_address    = r_addr;
  assign bus_byteenable = r_be;
  assign bus_writedata  = r_wdata;
  assign lsu_bus_error  = w_timeout;

  // Byte lanes and lane-replicated store data for the incoming request.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = lsu_req_writedata;
    case (lsu_req_mem_op[1:0])
      2'b00: begin
        w_be    = 4'(4'b0001 << lsu_req_address[1:0]);
        w_wdata = {4{lsu_req_writedata[7:0]}};
      end
      2'b01: begin
        w_be    = 4'(4'b0011 << lsu_req_address[1:0]);
        w_wdata = {2{lsu_req_writedata[15:0]}};
      end
      default: ;
    endcase
  end

  // Right-justify the addressed lanes and extend to 32 bits.
  always_comb begin
    w_shift = bus_readdata >> {r_lo, 3'b000};
    case (r_op)
      3'b000:  w_fmt = {{24{w_shift[7]}}, w_shift[7:0]};
      3'b001:  w_fmt = {{16{w_shift[15]}}, w_shift[15:0]};
      3'b100:  w_fmt = {24'h000000, w_shift[7:0]};
      3'b101:  w_fmt = {16'h0000, w_shift[15:0]};
      default: w_fmt = w_shift;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  // Abort only if the access is not completing in the same cycle.
  assign w_timeout = (r_cnt == CNT_LAST) &&
                     (((r_state == S_REQ) && bus_waitrequest) ||
                      ((r_state == S_WAIT_RD) && !bus_readdatavalid));

  // Watchdog counts cycles spent in REQ and WAIT_RD; zero elsewhere so entry to REQ starts at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if ((r_state == S_REQ) || (r_state == S_WAIT_RD)) begin
      r_cnt <= w_timeout ? '0 : r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= '0;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Stall and load-result outputs, decoded from the current state.
  always_comb begin
    lsu_stall_req     = 1'b0;
    lsu_readdatavalid = 1'b0;
    lsu_readdata      = 32'h0;
    case (r_state)
      S_IDLE:  lsu_stall_req = w_req;
      S_REQ:   lsu_stall_req = r_read | bus_waitrequest;
      S_WAIT_RD: begin
        lsu_stall_req = ~bus_readdatavalid;
        if (bus_readdatavalid) begin
          lsu_readdatavalid = 1'b1;
          lsu_readdata      = w_fmt;
        end
      end
      S_DONE: begin
        lsu_readdatavalid = r_is_load;
        lsu_readdata      = r_is_load ? r_held : 32'h0;
      end
      default: ;
    endcase
    if (w_timeout) begin
      lsu_stall_req     = 1'b0;
      lsu_readdatavalid = 1'b1;
      lsu_readdata      = 32'h0;
    end
  end

  // Access sequencer: register command, hold through waitrequest, await response, park in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_read    <= 1'b0;
      r_write   <= 1'b0;
      r_addr    <= 32'h0;
      r_lo      <= 2'b00;
      r_be      <= 4'h0;
      r_wdata   <= 32'h0;
      r_op      <= 3'b000;
      r_is_load <= 1'b0;
      r_held    <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_read    <= lsu_req_read;
            r_write   <= ~lsu_req_read;
            r_addr    <= {lsu_req_address[31:2], 2'b00};
            r_lo      <= lsu_req_address[1:0];
            r_be      <= w_be;
            r_wdata   <= w_wdata;
            r_op      <= lsu_req_mem_op;
            r_is_load <= lsu_req_read;
            r_state   <= S_REQ;
          end
        end
        S_REQ: begin
          if (!bus_waitrequest) begin
            r_read  <= 1'b0;
            r_write <= 1'b0;
            if (r_read) r_state <= S_WAIT_RD;
            else        r_state <= mem_stall_ext ? S_DONE : S_IDLE;
          end else if (w_timeout) begin
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_held  <= 32'h0;
            r_state <= mem_stall_ext ? S_DONE : S_IDLE;
          end
        end
        S_WAIT_RD: begin
          if (bus_readdatavalid) begin
            r_held  <= w_fmt;
            r_state <= mem_stall_ext ? S_DONE : S_IDLE;
          end else if (w_timeout) begin
            r_held  <= 32'h0;
            r_state <= mem_stall_ext ? S_DONE : S_IDLE;
          end
        end
        S_DONE: begin
          if (!mem_stall_ext) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Self-checking bench for lsu_bus_ctrl: vector table plus multi-cycle corner sequences.
module tb_lsu_bus_ctrl;
  localparam int unsigned TB_TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_req_read, lsu_req_write, mem_stall_ext;
  logic [2:0]  lsu_req_mem_op;
  logic [31:0] lsu_req_address, lsu_req_writedata;
  logic        lsu_stall_req, lsu_readdatavalid, lsu_bus_error;
  logic [31:0] lsu_readdata;
  logic        bus_read, bus_write, bus_waitrequest, bus_readdatavalid;
  logic [31:0] bus_address, bus_writedata, bus_readdata;
  logic [3:0]  bus_byteenable;

  lsu_bus_ctrl #(.TIMEOUT_CYCLES(TB_TO)) dut (
    .clk(clk), .rst(rst),
    .lsu_req_read(lsu_req_read), .lsu_req_write(lsu_req_write),
    .lsu_req_mem_op(lsu_req_mem_op), .lsu_req_address(lsu_req_address),
    .lsu_req_writedata(lsu_req_writedata), .mem_stall_ext(mem_stall_ext),
    .lsu_stall_req(lsu_stall_req), .lsu_readdatavalid(lsu_readdatavalid),
    .lsu_readdata(lsu_readdata), .lsu_bus_error(lsu_bus_error),
    .bus_read(bus_read), .bus_write(bus_write), .bus_address(bus_address),
    .bus_byteenable(bus_byteenable), .bus_writedata(bus_writedata),
    .bus_waitrequest(bus_waitrequest), .bus_readdatavalid(bus_readdatavalid),
    .bus_readdata(bus_readdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_data;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] sb_q[$];
  vec_t        vt[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk_sb(input string name);
    logic [31:0] e;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got %h want <none queued>", name, lsu_readdata);
    end else begin
      e = sb_q.pop_front();
      chk(name, lsu_readdata, e);
    end
  endtask

  task automatic clear_req();
    lsu_req_read      = 1'b0;
    lsu_req_write     = 1'b0;
    lsu_req_mem_op    = 3'b000;
    lsu_req_address   = 32'h0;
    lsu_req_writedata = 32'h0;
  endtask

  task automatic issue(input logic wr, input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
    lsu_req_read      = ~wr;
    lsu_req_write     = wr;
    lsu_req_mem_op    = op;
    lsu_req_address   = a;
    lsu_req_writedata = wd;
  endtask

  // One access with zero waitrequest and a response one cycle after acceptance.
  task automatic run_vec(input vec_t v);
    issue(v.wr, v.op, v.addr, v.wr ? v.data : 32'h0);
    bus_waitrequest = 1'b0;
    if (!v.wr) sb_q.push_back(v.e_data);
    smp;
    chk("idle_stall", 32'(lsu_stall_req), 32'd1);
    chk("idle_nocmd", 32'({bus_read, bus_write}), 32'd0);
    step;
    smp;
    chk("cmd_on", 32'(v.wr ? bus_write : bus_read), 32'd1);
    chk("cmd_other", 32'(v.wr ? bus_read : bus_write), 32'd0);
    chk("cmd_addr", bus_address, v.e_addr);
    chk("cmd_be", 32'(bus_byteenable), 32'(v.e_be));
    if (v.wr) begin
      chk("wr_data", bus_writedata, v.e_data);
      chk("wr_acc_stall", 32'(lsu_stall_req), 32'd0);
    end else begin
      chk("rd_acc_stall", 32'(lsu_stall_req), 32'd1);
    end
    step;
    if (!v.wr) begin
      bus_readdatavalid = 1'b1;
      bus_readdata      = v.data;
      smp;
      chk("rsp_cmd_off", 32'(bus_read), 32'd0);
      chk("rsp_stall", 32'(lsu_stall_req), 32'd0);
      chk("rsp_valid", 32'(lsu_readdatavalid), 32'd1);
      chk_sb("rsp_data");
      step;
      bus_readdatavalid = 1'b0;
      bus_readdata      = 32'h0;
    end
    clear_req();
    smp;
    chk("post_valid", 32'(lsu_readdatavalid), 32'd0);
    chk("post_cmd", 32'({bus_read, bus_write}), 32'd0);
    chk("post_err", 32'(lsu_bus_error), 32'd0);
    step;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    vt[0]  = '{1'b0, 3'b010, 32'h100, 32'hDEADBEEF, 32'h100, 4'hF,    32'hDEADBEEF};
    vt[1]  = '{1'b0, 3'b000, 32'h203, 32'h80123456, 32'h200, 4'b1000, 32'hFFFFFF80};
    vt[2]  = '{1'b0, 3'b100, 32'h203, 32'h80123456, 32'h200, 4'b1000, 32'h00000080};
    vt[3]  = '{1'b0, 3'b101, 32'h202, 32'h80123456, 32'h200, 4'b1100, 32'h00008012};
    vt[4]  = '{1'b0, 3'b001, 32'h202, 32'h80123456, 32'h200, 4'b1100, 32'hFFFF8012};
    vt[5]  = '{1'b0, 3'b000, 32'h201, 32'h80123456, 32'h200, 4'b0010, 32'h00000034};
    vt[6]  = '{1'b0, 3'b001, 32'h200, 32'h1234F00D, 32'h200, 4'b0011, 32'hFFFFF00D};
    vt[7]  = '{1'b0, 3'b100, 32'h200, 32'h1234F00D, 32'h200, 4'b0001, 32'h0000000D};
    vt[8]  = '{1'b0, 3'b000, 32'h202, 32'h80123456, 32'h200, 4'b0100, 32'h00000012};
    vt[9]  = '{1'b1, 3'b000, 32'h101, 32'h000000A5, 32'h100, 4'b0010, 32'hA5A5A5A5};
    vt[10] = '{1'b1, 3'b010, 32'h208, 32'h12345678, 32'h208, 4'hF,    32'h12345678};
    vt[11] = '{1'b1, 3'b001, 32'h100, 32'h00001234, 32'h100, 4'b0011, 32'h12341234};

    rst = 1'b1;
    clear_req();
    mem_stall_ext     = 1'b0;
    bus_waitrequest   = 1'b0;
    bus_readdatavalid = 1'b0;
    bus_readdata      = 32'h0;
    step;
    step;
    smp;
    chk("rst_read", 32'(bus_read), 32'd0);
    chk("rst_write", 32'(bus_write), 32'd0);
    chk("rst_addr", bus_address, 32'h0);
    chk("rst_be", 32'(bus_byteenable), 32'd0);
    chk("rst_wdata", bus_writedata, 32'h0);
    chk("rst_valid", 32'(lsu_readdatavalid), 32'd0);
    chk("rst_rdata", lsu_readdata, 32'h0);
    chk("rst_err", 32'(lsu_bus_error), 32'd0);
    chk("rst_stall", 32'(lsu_stall_req), 32'd0);
    step;
    rst = 1'b0;
    step;

    for (int i = 0; i < 12; i++) run_vec(vt[i]);

    // SH with waitrequest held 3 cycles: command stable for 4 cycles.
    issue(1'b1, 3'b001, 32'h106, 32'h0000ABCD);
    bus_waitrequest = 1'b1;
    step;
    for (int i = 0; i < 3; i++) begin
      smp;
      chk("sh_wait_write", 32'(bus_write), 32'd1);
      chk("sh_wait_addr", bus_address, 32'h104);
      chk("sh_wait_be", 32'(bus_byteenable), 32'(4'b1100));
      chk("sh_wait_data", bus_writedata, 32'hABCDABCD);
      chk("sh_wait_stall", 32'(lsu_stall_req), 32'd1);
      step;
    end
    bus_waitrequest = 1'b0;
    smp;
    chk("sh_acc_write", 32'(bus_write), 32'd1);
    chk("sh_acc_data", bus_writedata, 32'hABCDABCD);
    chk("sh_acc_stall", 32'(lsu_stall_req), 32'd0);
    step;
    clear_req();
    smp;
    chk("sh_post_write", 32'(bus_write), 32'd0);
    step;

    // LH with waitrequest then a late response.
    issue(1'b0, 3'b001, 32'h102, 32'h0);
    bus_waitrequest = 1'b1;
    sb_q.push_back(32'h00007FFF);
    step;
    for (int i = 0; i < 2; i++) begin
      smp;
      chk("lh_wait_read", 32'(bus_read), 32'd1);
      chk("lh_wait_be", 32'(bus_byteenable), 32'(4'b1100));
      chk("lh_wait_stall", 32'(lsu_stall_req), 32'd1);
      step;
    end
    bus_waitrequest = 1'b0;
    smp;
    chk("lh_acc_stall", 32'(lsu_stall_req), 32'd1);
    step;
    for (int i = 0; i < 2; i++) begin
      smp;
      chk("lh_gap_read", 32'(bus_read), 32'd0);
      chk("lh_gap_stall", 32'(lsu_stall_req), 32'd1);
      chk("lh_gap_valid", 32'(lsu_readdatavalid), 32'd0);
      step;
    end
    bus_readdatavalid = 1'b1;
    bus_readdata      = 32'h7FFF0000;
    smp;
    chk("lh_rsp_stall", 32'(lsu_stall_req), 32'd0);
    chk("lh_rsp_valid", 32'(lsu_readdatavalid), 32'd1);
    chk_sb("lh_rsp_data");
    step;
    bus_readdatavalid = 1'b0;
    bus_readdata      = 32'h0;
    clear_req();
    step;

    // Load completing under external stall parks in DONE without re-issue.
    issue(1'b0, 3'b010, 32'h300, 32'h0);
    sb_q.push_back(32'hCAFEF00D);
    step;
    smp;
    chk("done_cmd", 32'(bus_read), 32'd1);
    step;
    bus_readdatavalid = 1'b1;
    bus_readdata      = 32'hCAFEF00D;
    mem_stall_ext     = 1'b1;
    smp;
    chk_sb("done_rsp_data");
    step;
    bus_readdatavalid = 1'b0;
    bus_readdata      = 32'h0;
    for (int i = 0; i < 2; i++) begin
      if (i == 1) mem_stall_ext = 1'b0;
      smp;
      chk("done_valid", 32'(lsu_readdatavalid), 32'd1);
      chk("done_data", lsu_readdata, 32'hCAFEF00D);
      chk("done_stall", 32'(lsu_stall_req), 32'd0);
      chk("done_noreissue", 32'(bus_read), 32'd0);
      step;
    end
    clear_req();
    smp;
    chk("done_exit_valid", 32'(lsu_readdatavalid), 32'd0);
    chk("done_exit_read", 32'(bus_read), 32'd0);
    step;

    // Store accepted under external stall: DONE shows no load data.
    issue(1'b1, 3'b000, 32'h40, 32'h5A);
    step;
    mem_stall_ext = 1'b1;
    step;
    smp;
    chk("sdone_write", 32'(bus_write), 32'd0);
    chk("sdone_valid", 32'(lsu_readdatavalid), 32'd0);
    chk("sdone_stall", 32'(lsu_stall_req), 32'd0);
    mem_stall_ext = 1'b0;
    step;
    clear_req();
    smp;
    chk("sdone_exit", 32'(bus_write), 32'd0);
    step;

    // Reset in WAIT_RD aborts; the late response is ignored.
    issue(1'b0, 3'b010, 32'h400, 32'h0);
    step;
    step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    clear_req();
    bus_readdatavalid = 1'b1;
    bus_readdata      = 32'h11111111;
    smp;
    chk("rstmid_valid", 32'(lsu_readdatavalid), 32'd0);
    chk("rstmid_data", lsu_readdata, 32'h0);
    chk("rstmid_stall", 32'(lsu_stall_req), 32'd0);
    chk("rstmid_read", 32'(bus_read), 32'd0);
    chk("rstmid_addr", bus_address, 32'h0);
    chk("rstmid_be", 32'(bus_byteenable), 32'd0);
    step;
    bus_readdatavalid = 1'b0;
    bus_readdata      = 32'h0;
    smp;
    chk("rstmid_after_valid", 32'(lsu_readdatavalid), 32'd0);
    step;
    run_vec(vt[0]);

`ifdef LSU_TIMEOUT_EN
    // Stuck waitrequest: error pulse in the 8th REQ cycle.
    issue(1'b0, 3'b010, 32'h500, 32'h0);
    bus_waitrequest = 1'b1;
    step;
    for (int i = 1; i < int'(TB_TO); i++) begin
      smp;
      chk("to_wait_err", 32'(lsu_bus_error), 32'd0);
      chk("to_wait_read", 32'(bus_read), 32'd1);
      chk("to_wait_stall", 32'(lsu_stall_req), 32'd1);
      step;
    end
    smp;
    chk("to_err", 32'(lsu_bus_error), 32'd1);
    chk("to_stall", 32'(lsu_stall_req), 32'd0);
    chk("to_valid", 32'(lsu_readdatavalid), 32'd1);
    chk("to_data", lsu_readdata, 32'h0);
    step;
    bus_waitrequest = 1'b0;
    clear_req();
    smp;
    chk("to_post_read", 32'(bus_read), 32'd0);
    chk("to_post_err", 32'(lsu_bus_error), 32'd0);
    chk("to_post_valid", 32'(lsu_readdatavalid), 32'd0);
    step;
`endif

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
